// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one external memory port between instruction fetch
// (read-only) and the data-memory stage (loads/stores). Data wins by default;
// a starvation counter forces a fetch grant after MAX_DATA_BURST consecutive
// data grants made while fetch was waiting. A pipeline flush discards an
// in-flight fetch without aborting the bus transaction.
//
// Ports:
//   clock_i, reset_i            clock, synchronous active-high reset
//   ifetch_request_i/address_i  fetch request (held until ifetch_ack_o)
//   ifetch_ack_o/data_o         one-cycle completion pulse + instruction word
//   flush_i                     discards the in-flight fetch
//   dmem_request_i/write_i/address_i/write_data_i  data request
//   dmem_ack_o/read_data_o      one-cycle completion pulse + load data
//   mem_request_o/write_o/address_o/write_data_o   bus request side
//   mem_read_data_i/mem_ack_i   bus completion side
//
// state      | meaning
// -----------+-------------------------------------------
// IDLE       | no bus transaction, arbitration active
// BUSY_FETCH | fetch transaction on the bus
// BUSY_DATA  | data transaction on the bus
module memory_arbiter #(
   parameter int unsigned MAX_DATA_BURST = 4
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        ifetch_request_i,
   input  logic [31:0] ifetch_address_i,
   output logic        ifetch_ack_o,
   output logic [31:0] ifetch_data_o,
   input  logic        flush_i,
   input  logic        dmem_request_i,
   input  logic        dmem_write_i,
   input  logic [31:0] dmem_address_i,
   input  logic [31:0] dmem_write_data_i,
   output logic        dmem_ack_o,
   output logic [31:0] dmem_read_data_o,
   output logic        mem_request_o,
   output logic        mem_write_o,
   output logic [31:0] mem_address_o,
   output logic [31:0] mem_write_data_o,
   input  logic [31:0] mem_read_data_i,
   input  logic        mem_ack_i
);

   localparam int unsigned      CNT_W     = $clog2(MAX_DATA_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_DATA_BURST);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      BUSY_FETCH = 2'd1,
      BUSY_DATA  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic             discard_q, discard_d;

   logic        mem_request_q, mem_request_d;
   logic        mem_write_q, mem_write_d;
   logic [31:0] mem_address_q, mem_address_d;
   logic [31:0] mem_write_data_q, mem_write_data_d;
   logic        ifetch_ack_q, ifetch_ack_d;
   logic [31:0] ifetch_data_q, ifetch_data_d;
   logic        dmem_ack_q, dmem_ack_d;
   logic [31:0] dmem_read_data_q, dmem_read_data_d;

   // A requester whose ack is high this cycle still holds its request for one
   // more cycle; it must not be granted a second time.
   logic fetch_elig, data_elig, grant_data, grant_fetch;

   assign fetch_elig  = ifetch_request_i & ~flush_i & ~ifetch_ack_q;
   assign data_elig   = dmem_request_i & ~dmem_ack_q;
   assign grant_data  = (state_q == IDLE) & data_elig &
                        ((starve_q < BURST_MAX) | ~fetch_elig);
   assign grant_fetch = (state_q == IDLE) & ~grant_data & fetch_elig;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q          <= IDLE;
         starve_q         <= '0;
         discard_q        <= 1'b0;
         mem_request_q    <= 1'b0;
         mem_write_q      <= 1'b0;
         mem_address_q    <= '0;
         mem_write_data_q <= '0;
         ifetch_ack_q     <= 1'b0;
         ifetch_data_q    <= '0;
         dmem_ack_q       <= 1'b0;
         dmem_read_data_q <= '0;
      end else begin
         state_q          <= state_d;
         starve_q         <= starve_d;
         discard_q        <= discard_d;
         mem_request_q    <= mem_request_d;
         mem_write_q      <= mem_write_d;
         mem_address_q    <= mem_address_d;
         mem_write_data_q <= mem_write_data_d;
         ifetch_ack_q     <= ifetch_ack_d;
         ifetch_data_q    <= ifetch_data_d;
         dmem_ack_q       <= dmem_ack_d;
         dmem_read_data_q <= dmem_read_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_data)       state_d = BUSY_DATA;
            else if (grant_fetch) state_d = BUSY_FETCH;
         end
         BUSY_FETCH, BUSY_DATA: begin
            if (mem_ack_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_request_d    = mem_request_q;
      mem_write_d      = mem_write_q;
      mem_address_d    = mem_address_q;
      mem_write_data_d = mem_write_data_q;
      ifetch_ack_d     = 1'b0;
      ifetch_data_d    = ifetch_data_q;
      dmem_ack_d       = 1'b0;
      dmem_read_data_d = dmem_read_data_q;
      discard_d        = discard_q;

      case (state_q)
         IDLE: begin
            discard_d = 1'b0;
            if (grant_data) begin
               mem_request_d    = 1'b1;
               mem_write_d      = dmem_write_i;
               mem_address_d    = dmem_address_i;
               mem_write_data_d = dmem_write_data_i;
            end else if (grant_fetch) begin
               mem_request_d    = 1'b1;
               mem_write_d      = 1'b0;
               mem_address_d    = ifetch_address_i;
               mem_write_data_d = '0;
            end
         end
         BUSY_FETCH: begin
            if (mem_ack_i) begin
               mem_request_d = 1'b0;
               discard_d     = 1'b0;
               // A flush in the completion cycle also kills the delivery.
               if (!(discard_q || flush_i)) begin
                  ifetch_ack_d  = 1'b1;
                  ifetch_data_d = mem_read_data_i;
               end
            end else if (flush_i) begin
               discard_d = 1'b1;
            end
         end
         BUSY_DATA: begin
            if (mem_ack_i) begin
               mem_request_d = 1'b0;
               mem_write_d   = 1'b0;
               dmem_ack_d    = 1'b1;
               if (!mem_write_q) dmem_read_data_d = mem_read_data_i;
            end
         end
         default: ;
      endcase

      if (!ifetch_request_i || grant_fetch)
         starve_d = '0;
      else if (grant_data && (starve_q != BURST_MAX))
         starve_d = starve_q + CNT_ONE;
      else
         starve_d = starve_q;
   end

   assign mem_request_o    = mem_request_q;
   assign mem_write_o      = mem_write_q;
   assign mem_address_o    = mem_address_q;
   assign mem_write_data_o = mem_write_data_q;
   assign ifetch_ack_o     = ifetch_ack_q;
   assign ifetch_data_o    = ifetch_data_q;
   assign dmem_ack_o       = dmem_ack_q;
   assign dmem_read_data_o = dmem_read_data_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter. Requester models hold a request until its
// ack and keep it up through the ack cycle; a bus model answers after a
// programmable delay. Expected completions are queued when stimulus is issued
// and compared as acks are observed.
module tb_memory_arbiter;

   logic        clock_i = 1'b0;
   logic        reset_i;
   logic        ifetch_request_i = 1'b0;
   logic [31:0] ifetch_address_i = '0;
   logic        ifetch_ack_o;
   logic [31:0] ifetch_data_o;
   logic        flush_i;
   logic        dmem_request_i = 1'b0;
   logic        dmem_write_i = 1'b0;
   logic [31:0] dmem_address_i = '0;
   logic [31:0] dmem_write_data_i = '0;
   logic        dmem_ack_o;
   logic [31:0] dmem_read_data_o;
   logic        mem_request_o;
   logic        mem_write_o;
   logic [31:0] mem_address_o;
   logic [31:0] mem_write_data_o;
   logic [31:0] mem_read_data_i = '0;
   logic        mem_ack_i = 1'b0;

   always #5 clock_i = ~clock_i;

   memory_arbiter #(.MAX_DATA_BURST(4)) dut (
      .clock_i(clock_i), .reset_i(reset_i),
      .ifetch_request_i(ifetch_request_i), .ifetch_address_i(ifetch_address_i),
      .ifetch_ack_o(ifetch_ack_o), .ifetch_data_o(ifetch_data_o),
      .flush_i(flush_i),
      .dmem_request_i(dmem_request_i), .dmem_write_i(dmem_write_i),
      .dmem_address_i(dmem_address_i), .dmem_write_data_i(dmem_write_data_i),
      .dmem_ack_o(dmem_ack_o), .dmem_read_data_o(dmem_read_data_o),
      .mem_request_o(mem_request_o), .mem_write_o(mem_write_o),
      .mem_address_o(mem_address_o), .mem_write_data_o(mem_write_data_o),
      .mem_read_data_i(mem_read_data_i), .mem_ack_i(mem_ack_i)
   );

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
   } dreq_t;

   logic [31:0] fq[$];
   dreq_t       dq[$];
   dreq_t       d_cur;
   logic [31:0] exp_f[$], exp_d[$], obs_f[$], obs_d[$], glog[$];
   logic [31:0] bus_mem[logic [31:0]];
   logic [31:0] exp_mem[logic [31:0]];
   logic [31:0] exp_if_last = '0, exp_rd_last = '0;
   int          checks = 0, failures = 0;
   int unsigned ack_delay = 1, rcnt = 0;
   int          stray_req = 0, stray_done = 0;
   bit          flush_kills = 1'b0, f_done = 1'b0, d_done = 1'b0, prev_req = 1'b0;

   function automatic logic [31:0] base(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] a);
      return exp_mem.exists(a) ? exp_mem[a] : base(a);
   endfunction

   // Bus model: ack arrives ack_delay cycles after mem_request_o first rises.
   always @(negedge clock_i) begin
      if (mem_ack_i) begin
         mem_ack_i = 1'b0;
         rcnt      = 0;
      end else if (stray_req != stray_done) begin
         mem_ack_i       = 1'b1;
         mem_read_data_i = 32'hBAD0_0BAD;
         stray_done++;
      end else if (mem_request_o) begin
         if (rcnt == ack_delay) begin
            mem_ack_i = 1'b1;
            if (mem_write_o) bus_mem[mem_address_o] = mem_write_data_o;
            else mem_read_data_i = bus_mem.exists(mem_address_o) ?
                                   bus_mem[mem_address_o] : base(mem_address_o);
         end else begin
            rcnt++;
         end
      end else begin
         rcnt = 0;
      end
   end

   always @(negedge clock_i) begin
      if (ifetch_ack_o) obs_f.push_back(ifetch_data_o);
      if (dmem_ack_o)   obs_d.push_back(dmem_read_data_o);
      if (mem_request_o && !prev_req) glog.push_back(mem_address_o);
      prev_req = mem_request_o;
   end

   always @(negedge clock_i) begin
      if (reset_i) begin
         ifetch_request_i = 1'b0;
         f_done = 1'b0;
         fq.delete();
      end else if (flush_kills && flush_i) begin
         ifetch_request_i = 1'b0;
         f_done = 1'b0;
      end else begin
         if (f_done || !ifetch_request_i) begin
            f_done = 1'b0;
            if (fq.size() > 0) begin
               ifetch_address_i = fq.pop_front();
               ifetch_request_i = 1'b1;
            end else begin
               ifetch_request_i = 1'b0;
            end
         end
         if (ifetch_ack_o) f_done = 1'b1;
      end
   end

   always @(negedge clock_i) begin
      if (reset_i) begin
         dmem_request_i = 1'b0;
         d_done = 1'b0;
         dq.delete();
      end else begin
         if (d_done || !dmem_request_i) begin
            d_done = 1'b0;
            if (dq.size() > 0) begin
               d_cur             = dq.pop_front();
               dmem_address_i    = d_cur.addr;
               dmem_write_i      = d_cur.wr;
               dmem_write_data_i = d_cur.wdata;
               dmem_request_i    = 1'b1;
            end else begin
               dmem_request_i = 1'b0;
            end
         end
         if (dmem_ack_o) d_done = 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic score();
      logic [31:0] o;
      while (obs_f.size() > 0) begin
         o = obs_f.pop_front();
         check("ifetch_ack_expected", 32'(exp_f.size() > 0), 1);
         if (exp_f.size() > 0) check("ifetch_data", o, exp_f.pop_front());
      end
      while (obs_d.size() > 0) begin
         o = obs_d.pop_front();
         check("dmem_ack_expected", 32'(exp_d.size() > 0), 1);
         if (exp_d.size() > 0) check("dmem_read_data", o, exp_d.pop_front());
      end
   endtask

   task automatic tick();
      @(posedge clock_i);
      #1;
      score();
   endtask

   task automatic wait_memreq(input string tag, input int budget);
      int n = 0;
      while (!mem_request_o && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(mem_request_o), 1);
   endtask

   task automatic wait_glog(input string tag, input int size, input int budget);
      int n = 0;
      while (glog.size() < size && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(glog.size() >= size), 1);
   endtask

   task automatic check_glog(input string tag, input int idx, input logic [31:0] exp);
      if (glog.size() > idx) check(tag, glog[idx], exp);
      else check(tag, 32'(glog.size()), 32'(idx + 1));
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while ((exp_f.size() + exp_d.size()) > 0 && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(exp_f.size() + exp_d.size()), 0);
   endtask

   task automatic check_all_zero(input string p);
      check({p, "_mem_request"},    32'(mem_request_o), 0);
      check({p, "_mem_write"},      32'(mem_write_o), 0);
      check({p, "_mem_address"},    mem_address_o, 0);
      check({p, "_mem_write_data"}, mem_write_data_o, 0);
      check({p, "_ifetch_ack"},     32'(ifetch_ack_o), 0);
      check({p, "_ifetch_data"},    ifetch_data_o, 0);
      check({p, "_dmem_ack"},       32'(dmem_ack_o), 0);
      check({p, "_dmem_read_data"}, dmem_read_data_o, 0);
      check({p, "_state_idle"},     32'(dut.state_q), 0);
   endtask

   task automatic push_load(input logic [31:0] a);
      dq.push_back('{addr: a, wr: 1'b0, wdata: 32'h0});
      exp_rd_last = exp_read(a);
      exp_d.push_back(exp_rd_last);
   endtask

   task automatic push_fetch(input logic [31:0] a);
      fq.push_back(a);
      exp_if_last = exp_read(a);
      exp_f.push_back(exp_if_last);
   endtask

   initial begin
      int  n;
      bit  seen;
      int  g0;

      reset_i = 1'b1;
      flush_i = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      reset_i = 1'b0;
      tick();

      // Fetch only, bus answers 2 cycles after request: 4-cycle latency.
      ack_delay = 2;
      push_fetch(32'h100);
      n = 0; seen = 1'b0;
      while (!ifetch_ack_o && n < 20) begin
         tick();
         n++;
         if (mem_request_o && !seen) begin
            seen = 1'b1;
            check("fetch_mem_address", mem_address_o, 32'h100);
            check("fetch_mem_write", 32'(mem_write_o), 0);
         end
      end
      check("fetch_latency", 32'(n), 4);
      check("fetch_data_deadbeef", ifetch_data_o, 32'hDEADBEEF);
      drain("drain_fetch", 20);

      // Minimum latency: bus acks in the first request cycle.
      ack_delay = 0;
      push_fetch(32'h104);
      n = 0;
      while (!ifetch_ack_o && n < 20) begin
         tick();
         n++;
      end
      check("fetch_min_latency", 32'(n), 2);
      drain("drain_fetch_min", 20);

      // Simultaneous fetch and load: load first, fetch granted during dmem_ack_o.
      ack_delay = 1;
      g0 = glog.size();
      push_fetch(32'h200);
      push_load(32'h8000);
      n = 0;
      while (!dmem_ack_o && n < 20) begin
         tick();
         n++;
      end
      check("simul_dmem_ack_seen", 32'(dmem_ack_o), 1);
      check("simul_bus_idle_at_dack", 32'(mem_request_o), 0);
      tick();
      check("simul_fetch_granted", 32'(mem_request_o), 1);
      check("simul_fetch_addr", mem_address_o, 32'h200);
      check_glog("simul_first_grant_load", g0, 32'h8000);
      drain("drain_simul", 30);

      // Store: read data stays at the previous load's value.
      dq.push_back('{addr: 32'h40, wr: 1'b1, wdata: 32'h12345678});
      exp_mem[32'h40] = 32'h12345678;
      exp_d.push_back(exp_rd_last);
      wait_memreq("store_req_timeout", 20);
      check("store_mem_write", 32'(mem_write_o), 1);
      check("store_mem_address", mem_address_o, 32'h40);
      check("store_mem_write_data", mem_write_data_o, 32'h12345678);
      drain("drain_store", 20);
      push_load(32'h40);
      drain("drain_load_back", 20);
      check("load_back_data", dmem_read_data_o, 32'h12345678);

      // Flush in BUSY_FETCH before the bus completes.
      flush_kills = 1'b1;
      ack_delay = 3;
      fq.push_back(32'h180);
      wait_memreq("flush_req_timeout", 20);
      check("flush_fetch_addr", mem_address_o, 32'h180);
      tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      n = 0;
      while (mem_request_o && n < 20) begin
         tick();
         n++;
      end
      check("flush_no_ifetch_ack", 32'(ifetch_ack_o), 0);
      check("flush_data_kept", ifetch_data_o, exp_if_last);

      // Flush in the same cycle the bus completes the fetch.
      ack_delay = 1;
      fq.push_back(32'h380);
      wait_memreq("flush_ack_req_timeout", 20);
      tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("flush_ack_bus_done", 32'(mem_request_o), 0);
      check("flush_ack_no_ifetch_ack", 32'(ifetch_ack_o), 0);
      check("flush_ack_data_kept", ifetch_data_o, exp_if_last);
      tick();
      flush_kills = 1'b0;
      push_fetch(32'h300);
      drain("drain_after_flush", 20);
      check("after_flush_fetch_data", ifetch_data_o, base(32'h300));

      // Starvation: flush held keeps fetch ineligible while loads stream.
      ack_delay = 0;
      g0 = glog.size();
      flush_i = 1'b1;
      push_fetch(32'h400);
      for (int i = 0; i < 6; i++) push_load(32'h1000 + 32'(i * 4));
      wait_glog("starve_four_grants", g0 + 4, 60);
      check("starve_count_at_limit", 32'(dut.starve_q), 4);
      tick();
      flush_i = 1'b0;
      wait_glog("starve_fifth_grant", g0 + 5, 30);
      check_glog("starve_fetch_after_burst", g0 + 4, 32'h400);
      check("starve_count_cleared", 32'(dut.starve_q), 0);
      for (int i = 0; i < 4; i++)
         check_glog("starve_burst_addr", g0 + i, 32'h1000 + 32'(i * 4));
      drain("drain_starve", 80);
      check_glog("starve_data_resumes", g0 + 5, 32'h1010);

      // Reset while a load is on the bus.
      ack_delay = 50;
      dq.push_back('{addr: 32'h2000, wr: 1'b0, wdata: 32'h0});
      wait_memreq("reset_mid_req_timeout", 20);
      tick();
      reset_i = 1'b1;
      tick();
      check_all_zero("reset_mid");
      reset_i = 1'b0;
      exp_f.delete();
      exp_d.delete();
      exp_if_last = '0;
      exp_rd_last = '0;
      tick();
      ack_delay = 1;
      push_load(32'h2000);
      drain("drain_after_reset", 30);
      check("after_reset_load_data", dmem_read_data_o, base(32'h2000));

      // A bus ack while idle must be ignored.
      tick();
      stray_req++;
      tick();
      check("stray_no_ifetch_ack", 32'(ifetch_ack_o), 0);
      check("stray_no_dmem_ack", 32'(dmem_ack_o), 0);
      check("stray_no_bus_request", 32'(mem_request_o), 0);
      check("stray_dmem_data_kept", dmem_read_data_o, base(32'h2000));
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
